rc_failsafe: RTL and testbench

// - Sits between a 'radio' pulse decoder and its 'esc'/'servo' consumer, one instance per RC channel.
// - Watches the raw RC pulse line for activity and passes the decoded 10-bit value through while the link is alive.
// - On link loss, ramps the output to a safe DEFAULT. On recovery, re-arms only after a run of good pulses

---
 rtl/rc_failsafe_pkg.sv | 38 +++
 rtl/pulse_watchdog.sv | 45 ++++
 rtl/rc_failsafe.sv | 108 ++++++++++
 tb/tb_rc_failsafe.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rc_failsafe_pkg.sv
// rtl/rc_failsafe_pkg.sv - shared widths, state encodings and ramp helpers for the RC failsafe
package rc_failsafe_pkg;

  localparam int RC_VAL_W     = 10;
  localparam int RCFS_STATE_W = 2;

  typedef logic [RC_VAL_W-1:0] rc_val_t;

  localparam logic [RCFS_STATE_W-1:0] RCFS_WAIT    = 2'd0;
  localparam logic [RCFS_STATE_W-1:0] RCFS_PASS    = 2'd1;
  localparam logic [RCFS_STATE_W-1:0] RCFS_LOST    = 2'd2;
  localparam logic [RCFS_STATE_W-1:0] RCFS_RECOVER = 2'd3;

  function automatic rc_val_t abs_diff(input rc_val_t a, input rc_val_t b);
    logic [RC_VAL_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[RC_VAL_W]) d = -d;
    return d[RC_VAL_W-1:0];
  endfunction

  // One step toward target, landing exactly on it rather than overshooting.
  function automatic rc_val_t ramp_toward(input rc_val_t cur, input rc_val_t target,
                                          input rc_val_t step);
    logic [RC_VAL_W:0] gap;
    rc_val_t           res;
    res = target;
    gap = '0;
    if (cur > target) begin
      gap = {1'b0, cur} - {1'b0, target};
      if (gap > {1'b0, step}) res = cur - step;
    end else if (cur < target) begin
      gap = {1'b0, target} - {1'b0, cur};
      if (gap > {1'b0, step}) res = cur + step;
    end
    return res;
  endfunction

endpackage

// File: rtl/pulse_watchdog.sv
// rtl/pulse_watchdog.sv - sig synchronizer, rising-edge strobe and saturating ms-since-edge counter
module pulse_watchdog #(
  parameter int TIMEOUT_MS = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1khz,
  input  logic sig,
  output logic pulse_edge,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_MS);

  logic       sync_q1;
  logic       sync_q2;
  logic       prev_q;
  logic       edge_q;
  logic [7:0] ms_cnt_q;

  // Registered edge strobe so it trails sig by three clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      prev_q   <= 1'b0;
      edge_q   <= 1'b0;
      ms_cnt_q <= 8'd0;
    end else begin
      sync_q1 <= sig;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
      edge_q  <= sync_q2 & ~prev_q;
      if (edge_q) begin
        ms_cnt_q <= 8'd0;
      end else if (tick_1khz && (ms_cnt_q != LIMIT)) begin
        ms_cnt_q <= ms_cnt_q + 8'd1;
      end
    end
  end

  assign pulse_edge = edge_q;
  assign timeout    = (ms_cnt_q == LIMIT);

endmodule

// File: rtl/rc_failsafe.sv
// rtl/rc_failsafe.sv - per-channel RC link failsafe: pass-through, ramp to default, guarded re-arm
module rc_failsafe
  import rc_failsafe_pkg::*;
#(
  parameter rc_val_t DEFAULT     = 10'd0,
  parameter int      TIMEOUT_MS  = 50,
  parameter int      GOOD_PULSES = 10,
  parameter rc_val_t RAMP_STEP   = 10'd4,
  parameter rc_val_t ARM_BAND    = 10'd16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick_1khz,
  input  logic                    sig,
  input  logic [RC_VAL_W-1:0]     val_i,
  output logic [RC_VAL_W-1:0]     val_o,
  output logic                    lost,
  output logic [RCFS_STATE_W-1:0] state_o
);

  localparam logic [7:0] GOOD_LIMIT = 8'(GOOD_PULSES);

  logic                    pulse_edge;
  logic                    timeout;
  logic [RCFS_STATE_W-1:0] state_q, state_d;
  rc_val_t                 val_q, val_d;
  logic [7:0]              good_q, good_d;
  logic                    lost_q, lost_d;
  rc_val_t                 ramp_val;
  logic                    armed;

  pulse_watchdog #(.TIMEOUT_MS(TIMEOUT_MS)) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .tick_1khz  (tick_1khz),
    .sig        (sig),
    .pulse_edge (pulse_edge),
    .timeout    (timeout)
  );

  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    good_d   = good_q;
    ramp_val = tick_1khz ? ramp_toward(val_q, DEFAULT, RAMP_STEP) : val_q;
    armed    = (good_q == GOOD_LIMIT) && (abs_diff(val_i, val_q) <= ARM_BAND);
    case (state_q)
      RCFS_WAIT: begin
        val_d = DEFAULT;
        if (pulse_edge) begin
          state_d = RCFS_RECOVER;
          good_d  = 8'd1;
        end
      end
      RCFS_PASS: begin
        val_d = val_i;
        // An edge in the same clock as the timeout keeps the link alive.
        if (timeout && !pulse_edge) begin
          state_d = RCFS_LOST;
          val_d   = val_q;
        end
      end
      RCFS_LOST: begin
        val_d  = ramp_val;
        good_d = 8'd0;
        if (pulse_edge) begin
          state_d = RCFS_RECOVER;
          good_d  = 8'd1;
        end
      end
      RCFS_RECOVER: begin
        val_d = ramp_val;
        if (timeout && !pulse_edge) begin
          state_d = RCFS_LOST;
          good_d  = 8'd0;
        end else begin
          if (pulse_edge && !timeout && (good_q != GOOD_LIMIT)) good_d = good_q + 8'd1;
          if (armed) state_d = RCFS_PASS;
        end
      end
      default: begin
        state_d = RCFS_WAIT;
        val_d   = DEFAULT;
        good_d  = 8'd0;
      end
    endcase
    lost_d = (state_d != RCFS_PASS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RCFS_WAIT;
      val_q   <= DEFAULT;
      good_q  <= 8'd0;
      lost_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      good_q  <= good_d;
      lost_q  <= lost_d;
    end
  end

  assign val_o   = val_q;
  assign lost    = lost_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_rc_failsafe.sv
// tb/tb_rc_failsafe.sv - directed self-checking bench for rc_failsafe
module tb_rc_failsafe;
  import rc_failsafe_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1khz = 1'b0;
  logic       sig = 1'b0;
  logic [9:0] val_i = 10'd0;
  logic [9:0] val_i2 = 10'd514;
  logic [9:0] val_o, val_o2;
  logic       lost, lost2;
  logic [1:0] state_o, state_o2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         blk;
    logic [9:0] exp_val;
    logic [9:0] exp_val2;
  } ramp_vec_t;

  typedef struct {
    logic [9:0] vin;
    logic [1:0] exp_state;
  } arm_vec_t;

  always #5 clk = ~clk;

  rc_failsafe dut (
    .clk(clk), .rst(rst), .tick_1khz(tick_1khz), .sig(sig),
    .val_i(val_i), .val_o(val_o), .lost(lost), .state_o(state_o)
  );

  rc_failsafe #(.DEFAULT(10'd512)) dut_mid (
    .clk(clk), .rst(rst), .tick_1khz(tick_1khz), .sig(sig),
    .val_i(val_i2), .val_o(val_o2), .lost(lost2), .state_o(state_o2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clk1(input logic t, input logic s);
    tick_1khz = t;
    sig = s;
    @(posedge clk);
    #1;
  endtask

  // One millisecond = 10 clocks, tick on the first; optional pulse on sig.
  task automatic ms_block(input bit pulse);
    for (int i = 0; i < 10; i++) clk1(i == 0, pulse && (i < 5));
  endtask

  task automatic blocks(input int n);
    repeat (n) ms_block(1'b0);
  endtask

  // n pulses every 20 ms, ending on the last pulse block.
  task automatic pulse_train(input int n);
    for (int i = 0; i < n; i++) begin
      ms_block(1'b1);
      if (i < n - 1) blocks(19);
    end
  endtask

  ramp_vec_t ramp_tab[7];
  arm_vec_t  arm_tab[4];

  initial begin
    int prev;

    ramp_tab[0] = '{1, 10'd296, 10'd512};
    ramp_tab[1] = '{2, 10'd292, 10'd512};
    ramp_tab[2] = '{10, 10'd260, 10'd512};
    ramp_tab[3] = '{74, 10'd4, 10'd512};
    ramp_tab[4] = '{75, 10'd0, 10'd512};
    ramp_tab[5] = '{76, 10'd0, 10'd512};
    ramp_tab[6] = '{80, 10'd0, 10'd512};

    arm_tab[0] = '{10'd600, RCFS_RECOVER};
    arm_tab[1] = '{10'd17, RCFS_RECOVER};
    arm_tab[2] = '{10'd100, RCFS_RECOVER};
    arm_tab[3] = '{10'd16, RCFS_PASS};

    rst = 1'b1;
    clk1(0, 0);
    clk1(0, 0);
    chk("reset_state", state_o, RCFS_WAIT);
    chk("reset_val", val_o, 0);
    chk("reset_lost", lost, 1);
    chk("reset_mid_val", val_o2, 512);
    rst = 1'b0;

    // Link bring-up from WAIT; stick close to default so arming is allowed.
    val_i = 10'd8;
    blocks(60);
    chk("wait_idle_state", state_o, RCFS_WAIT);
    chk("wait_idle_val", val_o, 0);
    ms_block(1'b1);
    chk("first_edge_state", state_o, RCFS_RECOVER);
    chk("first_edge_lost", lost, 1);
    blocks(19);
    pulse_train(8);
    chk("ninth_edge_state", state_o, RCFS_RECOVER);
    blocks(19);
    ms_block(1'b1);
    chk("tenth_edge_state", state_o, RCFS_PASS);
    chk("tenth_edge_lost", lost, 0);
    chk("pass_val", val_o, 8);
    chk("mid_pass_state", state_o2, RCFS_PASS);
    chk("mid_pass_val", val_o2, 514);
    val_i = 10'd300;
    clk1(0, 0);
    chk("pass_latency_val", val_o, 300);

    // Signal stops: LOST after 50 ticks, then ramp down to default.
    blocks(49);
    chk("tick49_state", state_o, RCFS_PASS);
    blocks(1);
    chk("tick50_state", state_o, RCFS_LOST);
    chk("tick50_lost", lost, 1);
    chk("tick50_hold_val", val_o, 300);
    chk("mid_lost_state", state_o2, RCFS_LOST);
    chk("mid_hold_val", val_o2, 514);
    prev = 0;
    for (int i = 0; i < 7; i++) begin
      blocks(ramp_tab[i].blk - prev);
      prev = ramp_tab[i].blk;
      chk($sformatf("ramp_val_k%0d", ramp_tab[i].blk), val_o, ramp_tab[i].exp_val);
      chk($sformatf("mid_clamp_k%0d", ramp_tab[i].blk), val_o2, ramp_tab[i].exp_val2);
    end

    // Recovery gated by the arm band around val_o=0.
    val_i = 10'd600;
    pulse_train(10);
    chk("far_stick_state", state_o, RCFS_RECOVER);
    chk("far_stick_val", val_o, 0);
    for (int i = 0; i < 4; i++) begin
      val_i = arm_tab[i].vin;
      clk1(0, 0);
      chk($sformatf("arm_band_%0d", arm_tab[i].vin), state_o, arm_tab[i].exp_state);
    end
    clk1(0, 0);
    chk("arm_follow_val", val_o, 16);

    // Timeout in RECOVER returns to LOST and the count restarts.
    val_i = 10'd0;
    blocks(49);
    chk("s5_pass_hold", state_o, RCFS_PASS);
    blocks(1);
    chk("s5_lost", state_o, RCFS_LOST);
    pulse_train(5);
    chk("s5_recover5", state_o, RCFS_RECOVER);
    blocks(49);
    chk("s5_gap49", state_o, RCFS_RECOVER);
    blocks(1);
    chk("s5_gap50_state", state_o, RCFS_LOST);
    chk("s5_gap50_lost", lost, 1);
    pulse_train(9);
    chk("s5_nine_edges", state_o, RCFS_RECOVER);
    blocks(19);
    ms_block(1'b1);
    chk("s5_rearm", state_o, RCFS_PASS);

    // Edge landing on the same clock as the 50th tick: edge wins.
    blocks(49);
    chk("corner_pre", state_o, RCFS_PASS);
    clk1(0, 1);
    clk1(0, 1);
    clk1(0, 1);
    clk1(1, 1);
    repeat (6) clk1(0, 0);
    chk("corner_state", state_o, RCFS_PASS);
    chk("corner_lost", lost, 0);
    blocks(49);
    chk("corner_cleared", state_o, RCFS_PASS);

    // Reset mid-operation lands straight on default, no ramp.
    val_i = 10'd700;
    clk1(0, 0);
    clk1(0, 0);
    chk("pre_rst_val", val_o, 700);
    rst = 1'b1;
    clk1(0, 0);
    chk("rst_val", val_o, 0);
    chk("rst_lost", lost, 1);
    chk("rst_state", state_o, RCFS_WAIT);
    chk("rst_mid_val", val_o2, 512);
    chk("rst_mid_state", state_o2, RCFS_WAIT);
    rst = 1'b0;
    blocks(3);
    chk("post_rst_state", state_o, RCFS_WAIT);
    chk("post_rst_val", val_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
